bcd_counter_mdigit: RTL
=======================

// Module: bcd_counter_mdigit
// PURPOSE
//   Parametrised multi-digit BCD counter: DIGITS cascaded decade stages (0-9 each),
//   up/down count, synchronous clear and parallel load, wrap or saturate at limits.
//   Registered count output plus terminal-count and overflow flags for chaining into
//   display drivers, timers and further counter stages.
// PARAMETERS
//   DIGITS  4  number of BCD digits; q width = 4*DIGITS; legal range 1..8
//   WRAP    1  1: wrap 99..9<->00..0 at the limits; 0: saturate at the limit
// PORTS
//   clk       in   1         rising-edge clock
//   reset_n   in   1         asynchronous active-low reset
//   en        in   1         count enable; one step per clock while high
//   up        in   1         1 = count up, 0 = count down; sampled with en
//   clr       in   1         synchronous clear to all zeros
//   load      in   1         synchronous parallel load of load_val
//   load_val  in   4*DIGITS  BCD load value; digit 0 = bits [3:0] (least significant)
//   q         out  4*DIGITS  registered BCD count; digit k = q[4k+3:4k]
//   tc        out  1         combinational terminal count (see BEHAVIOUR)
//   ovf       out  1         registered one-cycle wrap/saturate pulse
//   load_err  out  1         registered load-rejected pulse (BCD_CNT_LOAD_CHECK_EN only)
// BEHAVIOUR
//   - Reset (reset_n=0, async): q=0, ovf=0, load_err=0. Takes effect mid-operation
//     immediately, independent of clk. Release is sampled on the next rising edge.
//   - Priority on each rising edge: clr > load > en. Lower-priority requests in the
//     same cycle are dropped; ovf=0 on clr or load cycles.
//   - q is registered; the effect of any command is visible the cycle after it is sampled.
//   - Up step: digit 0 increments. Digit k increments only when digits 0..k-1 are all 9.
//     A digit at 9 that increments becomes 0.
//   - Down step: digit 0 decrements. Digit k decrements only when digits 0..k-1 are all 0.
//     A digit at 0 that decrements becomes 9.
//   - No binary arithmetic across digit boundaries. Every digit of q is always 0..9.
//   - tc = en & (up ? (q == all 9s) : (q == all 0s)). It is purely combinational, so
//     a higher-order counter's en can be driven from this stage's tc.
//   - At the limit with en=1:
//     - WRAP=1: q goes 99..9 -> 00..0 (up) or 00..0 -> 99..9 (down); ovf=1 for the
//       next cycle.
//     - WRAP=0: q holds at the limit; ovf=1 for each cycle a step is blocked.
//   - up may change on any cycle. A direction reversal takes effect on that same edge,
//     with no pipeline bubble.
//   - en=0 with no clr/load: q holds, ovf=0.
// CONFIGURATION
//   BCD_CNT_LOAD_CHECK_EN
//     Defined:
//       - On a load cycle, if any digit of load_val is >9, the whole load is rejected.
//       - q holds its previous value; load_err=1 for the following cycle.
//       - Valid loads give load_err=0.
//     Undefined:
//       - Each load_val digit >9 is clamped to 9 on load.
//       - load_err is tied to 0; the port is always present.
// TESTING
//   1 Reset: hold reset_n=0 mid-count at q=0x0473 -> q=0x0000 without a clock edge;
//     ovf=0, load_err=0.
//   2 Up carry chain: load 0x0999, en=1, up=1 -> q=0x1000 after one clock; tc=0.
//     Load 0x9999 -> tc=1, next q=0x0000, ovf=1 for exactly one cycle.
//   3 Down borrow: load 0x1000, en=1, up=0 -> q=0x0999.
//     At 0x0000, with WRAP=0 -> q holds 0x0000, ovf=1 while en held.
//     With WRAP=1 -> q=0x9999.
//   4 Priority: clr=1, load=1 (0x1234), en=1 in the same cycle -> q=0x0000.
//     load=1, en=1 -> q=0x1234 (no step).
//   5 Load check, load_val=0x12A4:
//     - Macro defined: q unchanged, load_err=1 for one cycle.
//     - Macro undefined: q=0x1294, load_err=0.
//   6 Sweep, DIGITS=2, WRAP=1: 200 up steps from 0x00 -> every digit <=9 each cycle.
//     Final q=0x00; ovf pulses exactly twice.

Source files
------------

// File: rtl/bcd_counter_mdigit_if.sv
// Bundle for the multi-digit BCD counter: control/load inputs plus count and flags.
// Ports: en, up, clr, load, load_val (to counter); q, tc, ovf, load_err (from counter).
interface bcd_counter_mdigit_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  tc;
    logic                  ovf;
    logic                  load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  q, tc, ovf, load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output q, tc, ovf, load_err
    );
endinterface

// File: rtl/bcd_counter_mdigit.sv
// Multi-digit up/down BCD counter with clear, load, wrap/saturate, tc and ovf flags.
// Ports: clk, reset_n (async, active low), bus (slave modport of bcd_counter_mdigit_if).
// Optional macro BCD_CNT_LOAD_CHECK_EN: reject loads with a non-BCD digit (load_err pulse);
// when undefined, non-BCD load digits clamp to 9 and load_err stays 0.
module bcd_counter_mdigit #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bcd_counter_mdigit_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] step_v;
    logic [W-1:0] load_v;
    logic         all9, all0, at_lim;
    logic         prop;
    logic [3:0]   dig, ld;
`ifdef BCD_CNT_LOAD_CHECK_EN
    logic         bad;
    logic         lerr_q, lerr_d;
`endif

    assign all9   = (q_q == {DIGITS{4'h9}});
    assign all0   = (q_q == {W{1'b0}});
    assign at_lim = bus.up ? all9 : all0;
    assign bus.tc = bus.en & at_lim;

    // Ripple the carry/borrow digit by digit; prop is "all lower digits at 9 (or 0)".
    always_comb begin
        step_v = q_q;
        prop   = 1'b1;
        dig    = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = q_q[4*k +: 4];
            if (bus.up) begin
                if (prop) step_v[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                prop = prop & (dig == 4'd9);
            end else begin
                if (prop) step_v[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                prop = prop & (dig == 4'd0);
            end
        end
    end

    always_comb begin
        load_v = bus.load_val;
        ld     = 4'h0;
`ifdef BCD_CNT_LOAD_CHECK_EN
        bad    = 1'b0;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            ld = bus.load_val[4*k +: 4];
            if (ld > 4'd9) begin
                load_v[4*k +: 4] = 4'd9;
`ifdef BCD_CNT_LOAD_CHECK_EN
                bad = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        q_d    = q_q;
        ovf_d  = 1'b0;
`ifdef BCD_CNT_LOAD_CHECK_EN
        lerr_d = 1'b0;
`endif
        if (bus.clr) begin
            q_d = {W{1'b0}};
        end else if (bus.load) begin
`ifdef BCD_CNT_LOAD_CHECK_EN
            if (bad) lerr_d = 1'b1;
            else     q_d    = load_v;
`else
            q_d = load_v;
`endif
        end else if (bus.en) begin
            if (at_lim) begin
                ovf_d = 1'b1;
                // step_v already holds the wrapped value at the limit
                q_d   = WRAP ? step_v : q_q;
            end else begin
                q_d = step_v;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q   <= {W{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef BCD_CNT_LOAD_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lerr_q <= 1'b0;
        else          lerr_q <= lerr_d;
    end
    assign bus.load_err = lerr_q;
`else
    assign bus.load_err = 1'b0;
`endif

    assign bus.q   = q_q;
    assign bus.ovf = ovf_q;
endmodule
